// File: rtl/uart_rx.sv
`default_nettype none
// ---- uart_rx : mid-bit sampling serial receiver (start/data/stop, LSB first) ----
// ---- rev 1.0                                                                  ----
module uart_rx #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx: CLOCK_FREQ / BAUD_RATE must be at least 4");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx: DATA_BITS must be in 5..9");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [DATA_BITS-1:0] data_nxt;
   logic                 valid_nxt, err_nxt;
   logic                 rx_meta, rx_s, rx_prev;
   logic [2:0]           warm;

   // The sync/edge flops reset to 1, so their contents are only trusted once
   // real line samples have flushed through; this stops a line held low out
   // of reset from looking like a start edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
         warm    <= 3'b000;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
         warm    <= {warm[1:0], 1'b1};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         shreg        <= shreg_nxt;
         rx_data      <= data_nxt;
         rx_valid     <= valid_nxt;
         rx_frame_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      data_nxt  = rx_data;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (warm[2] && rx_prev && !rx_s) begin
               cnt_nxt   = '0;
               state_nxt = START;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  idx_nxt   = '0;
                  state_nxt = DATA;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
               idx_nxt   = idx + IDX_W'(1);
               if (idx == IDX_LAST) begin
                  state_nxt = STOP;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            // Leave at mid stop bit; the remaining half bit absorbs a
            // back-to-back start edge.
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               if (rx_s) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---- tb_uart_rx : scoreboard bench for uart_rx at 100 Hz / 2 baud (50 clocks per bit) ----
module tb_uart_rx;

   localparam int CPB = 50;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         t_start = 0;
   int         pops = 0;
   bit         done = 1'b0;
   logic       rst_seen = 1'b1;
   logic [7:0] prev_data = 8'h00;
   bit         prev_pulse = 1'b0;

   uart_rx #(
      .CLOCK_FREQ(100),
      .BAUD_RATE (2),
      .DATA_BITS (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_frame_err(rx_frame_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic expect_frame(input bit is_err, input logic [7:0] d);
      exp_t e;
      e.is_err = is_err;
      e.data   = d;
      sb_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_level);
      rx = 1'b0;
      hold(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         hold(CPB);
      end
      rx = stop_level;
      hold(CPB);
   endtask

   // Monitor: owns every comparison and the counters.
   always @(negedge clock) begin
      exp_t e;
      if (rst_seen) begin
         checks += 3;
         if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h expected 00", rx_data);
         end
         if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
         end
         if (rx_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_frame_err: got %b expected 0", rx_frame_err);
         end
      end else begin
         if (rx_valid && rx_frame_err) begin
            errors++;
            $display("FAIL exclusive_pulses: valid=%b frame_err=%b expected not both", rx_valid, rx_frame_err);
         end
         if ((rx_valid || rx_frame_err) && prev_pulse) begin
            errors++;
            $display("FAIL pulse_width: pulse high on consecutive cycles, expected single cycle");
         end
         if (!rx_valid && rx_data !== prev_data) begin
            errors++;
            $display("FAIL data_hold: rx_data changed %h -> %h without rx_valid", prev_data, rx_data);
         end
         if (rx_valid || rx_frame_err) begin
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: valid=%b frame_err=%b data=%h with nothing expected",
                        rx_valid, rx_frame_err, rx_data);
            end else begin
               e = sb_q.pop_front();
               checks += 2;
               if (rx_frame_err !== e.is_err) begin
                  errors++;
                  $display("FAIL frame_kind: got frame_err=%b expected %b", rx_frame_err, e.is_err);
               end
               if (!e.is_err && rx_data !== e.data) begin
                  errors++;
                  $display("FAIL rx_data: got %h expected %h", rx_data, e.data);
               end
               if (e.is_err && rx_data !== prev_data) begin
                  errors++;
                  $display("FAIL err_data_kept: got %h expected %h", rx_data, prev_data);
               end
               if (pops == 0) begin
                  checks++;
                  if ((cyc - t_start) < 477 || (cyc - t_start) > 479) begin
                     errors++;
                     $display("FAIL latency: got %0d cycles expected 478 +/- 1", cyc - t_start);
                  end
               end
               pops++;
            end
         end
      end
      prev_data  = rx_data;
      prev_pulse = rx_valid || rx_frame_err;
      if (done) begin
         checks++;
         if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_frames: %0d expected frames never received, expected 0", sb_q.size());
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      hold(3);
      reset = 1'b0;
      hold(20);

      // Two back-to-back frames.
      t_start = cyc;
      expect_frame(1'b0, 8'hA5);
      send_byte(8'hA5, 1'b1);
      expect_frame(1'b0, 8'h3C);
      send_byte(8'h3C, 1'b1);
      hold(100);

      // Short low glitch must be rejected.
      rx = 1'b0;
      hold(10);
      rx = 1'b1;
      hold(100);
      expect_frame(1'b0, 8'h55);
      send_byte(8'h55, 1'b1);
      hold(100);

      // Framing error, then recovery.
      expect_frame(1'b1, 8'h00);
      send_byte(8'hFF, 1'b0);
      rx = 1'b1;
      hold(100);
      expect_frame(1'b0, 8'h12);
      send_byte(8'h12, 1'b1);
      hold(100);

      // Reset in the middle of bit 4 of 0xF0 aborts the frame.
      rx = 1'b0;
      hold(5 * CPB);
      rx = 1'b1;
      hold(CPB / 2);
      reset = 1'b1;
      hold(1);
      reset = 1'b0;
      hold(600);
      expect_frame(1'b0, 8'hC3);
      send_byte(8'hC3, 1'b1);
      hold(100);

      // Line held low out of reset for 20 bit times.
      rx    = 1'b0;
      reset = 1'b1;
      hold(2);
      reset = 1'b0;
      hold(20 * CPB);
      rx = 1'b1;
      hold(100);
      expect_frame(1'b0, 8'h81);
      send_byte(8'h81, 1'b1);
      hold(100);

      done = 1'b1;
      hold(5);
      $display("FAIL monitor_end: monitor did not finish the run");
      $fatal(1);
   end

endmodule
`default_nettype wire
